// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Runs beside the single-cycle ALU and stalls the pipeline while a divide is in flight.
// Optional feature macro: DIV_EARLY_OUT_EN (skip the iteration loop when |dividend| < |divisor|).
module div_sequencer #(
   parameter int DATA_WIDTH   = 32,
   parameter int ALUCTR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ALUCTR_WIDTH-1:0] alu_ctrl,
   input  logic [DATA_WIDTH-1:0]   src_a,
   input  logic [DATA_WIDTH-1:0]   src_b,
   input  logic                    flush,
   output logic                    stall,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   result
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0]   ALL_ONES = {DATA_WIDTH{1'b1}};
   localparam logic [DATA_WIDTH-1:0]   MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0]   ZERO     = {DATA_WIDTH{1'b0}};
   localparam logic [ALUCTR_WIDTH-1:0] OP_DIV   = ALUCTR_WIDTH'(5'b01110);
   localparam logic [ALUCTR_WIDTH-1:0] OP_DIVU  = ALUCTR_WIDTH'(5'b01111);
   localparam logic [ALUCTR_WIDTH-1:0] OP_REM   = ALUCTR_WIDTH'(5'b10000);
   localparam logic [ALUCTR_WIDTH-1:0] OP_REMU  = ALUCTR_WIDTH'(5'b10001);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // True for the four divide/remainder codes; everything else stays on the ALU path.
   function automatic logic is_div_code(input logic [ALUCTR_WIDTH-1:0] code);
      return (code == OP_DIV) || (code == OP_DIVU) || (code == OP_REM) || (code == OP_REMU);
   endfunction

   // Two's-complement magnitude of a value when it is interpreted as signed.
   function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                        input logic               is_signed);
      if (is_signed && v[DATA_WIDTH-1]) begin
         return ZERO - v;
      end else begin
         return v;
      end
   endfunction

   state_t                 state;
   state_t                 next_state;

   logic [DATA_WIDTH-1:0]  op_a;
   logic [DATA_WIDTH-1:0]  op_b;
   logic                   op_signed;
   logic                   op_rem;
   logic                   q_neg;
   logic                   r_neg;
   logic [DATA_WIDTH-1:0]  quo;
   logic [DATA_WIDTH-1:0]  rem;
   logic [DATA_WIDTH-1:0]  divisor;
   logic [CNT_W-1:0]       cnt;

   logic                   accept;
   logic                   load_result;
   logic [DATA_WIDTH-1:0]  result_next;
   logic [DATA_WIDTH-1:0]  abs_a;
   logic [DATA_WIDTH-1:0]  abs_b;
   logic                   div_zero;
   logic                   overflow;
   logic                   early_out;
   logic [DATA_WIDTH:0]    rem_shift;
   logic [DATA_WIDTH:0]    trial;
   logic                   trial_ok;
   logic [DATA_WIDTH-1:0]  quo_fix;
   logic [DATA_WIDTH-1:0]  rem_fix;

   // Operand preparation, the trial subtraction and the final sign fix-up.
   always_comb begin
      abs_a     = magnitude(op_a, op_signed);
      abs_b     = magnitude(op_b, op_signed);
      div_zero  = (op_b == ZERO);
      overflow  = op_signed && (op_a == MIN_NEG) && (op_b == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
      early_out = (abs_a < abs_b);
`else
      early_out = 1'b0;
`endif
      rem_shift = {rem, quo[DATA_WIDTH-1]};
      trial     = rem_shift - {1'b0, divisor};
      trial_ok  = ~trial[DATA_WIDTH];
      if (q_neg) begin
         quo_fix = ZERO - quo;
      end else begin
         quo_fix = quo;
      end
      if (r_neg) begin
         rem_fix = ZERO - rem;
      end else begin
         rem_fix = rem;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus stall/busy/done and the value to latch into result.
   always_comb begin
      next_state  = state;
      stall       = 1'b0;
      accept      = 1'b0;
      load_result = 1'b0;
      result_next = result;
      busy        = (state != S_IDLE);
      done        = (state == S_DONE) && !flush;
      case (state)
         S_IDLE: begin
            if (start && is_div_code(alu_ctrl) && !flush) begin
               accept     = 1'b1;
               stall      = 1'b1;
               next_state = S_PREP;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_PREP: begin
            if (flush) begin
               next_state = S_IDLE;
            end else if (div_zero) begin
               stall       = 1'b1;
               next_state  = S_DONE;
               load_result = 1'b1;
               result_next = op_rem ? op_a : ALL_ONES;
            end else if (overflow) begin
               stall       = 1'b1;
               next_state  = S_DONE;
               load_result = 1'b1;
               result_next = op_rem ? ZERO : MIN_NEG;
            end else if (early_out) begin
               stall      = 1'b1;
               next_state = S_FIX;
            end else begin
               stall      = 1'b1;
               next_state = S_CALC;
            end
         end
         S_CALC: begin
            if (flush) begin
               next_state = S_IDLE;
            end else if (cnt == CNT_LAST) begin
               stall      = 1'b1;
               next_state = S_FIX;
            end else begin
               stall      = 1'b1;
               next_state = S_CALC;
            end
         end
         S_FIX: begin
            if (flush) begin
               next_state = S_IDLE;
            end else begin
               stall       = 1'b1;
               next_state  = S_DONE;
               load_result = 1'b1;
               result_next = op_rem ? rem_fix : quo_fix;
            end
         end
         S_DONE: begin
            // The instruction that produced this result is still in EX, so start is ignored.
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Operand latch, PREP setup and one restoring-division step per CALC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a      <= ZERO;
         op_b      <= ZERO;
         op_signed <= 1'b0;
         op_rem    <= 1'b0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         quo       <= ZERO;
         rem       <= ZERO;
         divisor   <= ZERO;
         cnt       <= {CNT_W{1'b0}};
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_a      <= src_a;
                  op_b      <= src_b;
                  op_signed <= (alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM);
                  op_rem    <= (alu_ctrl == OP_REM) || (alu_ctrl == OP_REMU);
               end
            end
            S_PREP: begin
               q_neg   <= op_signed && (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
               r_neg   <= op_signed && op_a[DATA_WIDTH-1];
               divisor <= abs_b;
               cnt     <= {CNT_W{1'b0}};
               if (early_out) begin
                  quo <= ZERO;
                  rem <= abs_a;
               end else begin
                  quo <= abs_a;
                  rem <= ZERO;
               end
            end
            S_CALC: begin
               quo <= {quo[DATA_WIDTH-2:0], trial_ok};
               rem <= trial_ok ? trial[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
               cnt <= cnt + CNT_W'(1);
            end
            default: begin
               cnt <= cnt;
            end
         endcase
      end
   end

   // Result register: written on entry to DONE and held until the next completed divide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= ZERO;
      end else if (load_result) begin
         result <= result_next;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed test-plan cases plus randomized
// operations, all compared every cycle against a cycle-level behavioural model.
module tb_div_sequencer;

   localparam logic [4:0] C_DIV  = 5'b01110;
   localparam logic [4:0] C_DIVU = 5'b01111;
   localparam logic [4:0] C_REM  = 5'b10000;
   localparam logic [4:0] C_REMU = 5'b10001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  alu_ctrl = 5'b00000;
   logic [31:0] src_a = 32'h0;
   logic [31:0] src_b = 32'h0;
   logic        flush = 1'b0;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int passed = 0;
   int total  = 0;

   div_sequencer #(.DATA_WIDTH(32), .ALUCTR_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .stall(stall), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic bit is_div(input logic [4:0] c);
      return (c == C_DIV) || (c == C_DIVU) || (c == C_REM) || (c == C_REMU);
   endfunction

   // Architectural result of the RV32M operation.
   function automatic logic [31:0] ref_res(input logic [4:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      bit sgn = (c == C_DIV) || (c == C_REM);
      bit want_rem = (c == C_REM) || (c == C_REMU);
      logic signed [31:0] sa = a;
      logic signed [31:0] sb = b;
      logic [31:0] q, r;
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'h0;
      end else if (sgn) begin
         q = sa / sb; r = sa % sb;
      end else begin
         q = a / b; r = a % b;
      end
      return want_rem ? r : q;
   endfunction

   // Cycle (relative to the start cycle) in which done must pulse.
   function automatic int ref_lat(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      bit sgn = (c == C_DIV) || (c == C_REM);
      logic [31:0] ma = (sgn && a[31]) ? -a : a;
      logic [31:0] mb = (sgn && b[31]) ? -b : b;
      if (b == 32'h0) return 2;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) return 3;
`else
      if (ma < mb) return 35;
`endif
      return 35;
   endfunction

   // Behavioural model: tracks one operation as "k cycles since acceptance".
   bit          m_active = 1'b0;
   int          m_k = 0;
   int          m_lat = 0;
   logic [31:0] m_new = 32'h0;
   logic [31:0] m_last = 32'h0;

   // Per-cycle compare of every output against the model, then model advance.
   always @(negedge clk) begin
      logic e_stall, e_busy, e_done;
      logic [31:0] e_res;
      if (!rst_n) begin
         chk("rst_stall", {31'h0, stall}, 32'h0);
         chk("rst_busy", {31'h0, busy}, 32'h0);
         chk("rst_done", {31'h0, done}, 32'h0);
         chk("rst_result", result, 32'h0);
         m_active = 1'b0;
         m_last = 32'h0;
      end else begin
         if (!m_active) begin
            e_busy = 1'b0; e_done = 1'b0; e_res = m_last;
            e_stall = start && is_div(alu_ctrl) && !flush;
         end else begin
            e_busy = 1'b1;
            e_done = (m_k == m_lat) && !flush;
            e_stall = (m_k < m_lat) && !flush;
            e_res = (m_k == m_lat) ? m_new : m_last;
         end
         chk("stall", {31'h0, stall}, {31'h0, e_stall});
         chk("busy", {31'h0, busy}, {31'h0, e_busy});
         chk("done", {31'h0, done}, {31'h0, e_done});
         chk("result", result, e_res);
         if (!m_active) begin
            if (start && is_div(alu_ctrl) && !flush) begin
               m_active = 1'b1; m_k = 1;
               m_lat = ref_lat(alu_ctrl, src_a, src_b);
               m_new = ref_res(alu_ctrl, src_a, src_b);
            end
         end else if (m_k == m_lat) begin
            m_last = m_new; m_active = 1'b0;
         end else if (flush) begin
            m_active = 1'b0;
         end else begin
            m_k++;
         end
      end
   end

   // Present an op for one cycle (cycle 0); returns #1 into cycle 1.
   task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; alu_ctrl = c; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output logic [31:0] res);
      lat = -1; res = 32'h0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = n; res = result;
            break;
         end
         @(posedge clk);
      end
   endtask

   task automatic run_op(input string name, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
      int lat;
      logic [31:0] res;
      issue(c, a, b);
      wait_done(lat, res);
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_res"}, res, exp_res);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'($urandom_range(0, 20));
         1: return 32'h0;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return $urandom;
         default: return $urandom >> $urandom_range(0, 31);
      endcase
   endfunction

   function automatic logic [4:0] rand_ctrl();
      logic [4:0] codes [4] = '{C_DIV, C_DIVU, C_REM, C_REMU};
      int s = $urandom_range(0, 9);
      if (s < 8) return codes[s % 4];
      if (s == 8) return 5'b00000;
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      int early_lat;
`ifdef DIV_EARLY_OUT_EN
      early_lat = 3;
`else
      early_lat = 35;
`endif
      // Pin the model against hand-computed values.
      chk("model_divu", ref_res(C_DIVU, 32'd100, 32'd7), 32'd14);
      chk("model_rem", ref_res(C_REM, -32'sd7, 32'd2), 32'hFFFF_FFFF);
      chk("model_div", ref_res(C_DIV, -32'sd7, 32'd2), 32'hFFFF_FFFD);
      chk("model_div0", ref_res(C_DIV, 32'd5, 32'd0), 32'hFFFF_FFFF);
      chk("model_ovf", ref_res(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("model_lat", 32'(ref_lat(C_DIVU, 32'd100, 32'd7)), 32'd35);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      run_op("divu_100_7", C_DIVU, 32'd100, 32'd7, 35, 32'd14);
      run_op("rem_m7_2", C_REM, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF);
      run_op("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFD);
      run_op("div_5_0", C_DIV, 32'd5, 32'd0, 2, 32'hFFFF_FFFF);
      run_op("remu_5_0", C_REMU, 32'd5, 32'd0, 2, 32'd5);
      run_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000);
      run_op("rem_ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h0);
      run_op("divu_3_10", C_DIVU, 32'd3, 32'd10, early_lat, 32'd0);

      // Flush at cycle 10 of a DIVU, then a clean DIVU 9/3.
      issue(C_DIVU, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_busy", {31'h0, busy}, 32'h0);
      run_op("divu_9_3", C_DIVU, 32'd9, 32'd3, 35, 32'd3);

      // Non-divide code and start-with-flush are both ignored.
      @(posedge clk); #1;
      start = 1'b1; alu_ctrl = 5'b00000; src_a = 32'd8; src_b = 32'd2;
      #1 chk("nondiv_stall", {31'h0, stall}, 32'h0);
      @(posedge clk); #1;
      chk("nondiv_busy", {31'h0, busy}, 32'h0);
      alu_ctrl = C_DIVU; flush = 1'b1;
      #1 chk("flush_idle_stall", {31'h0, stall}, 32'h0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_idle_busy", {31'h0, busy}, 32'h0);

      // Reset in the middle of an operation.
      issue(C_DIVU, 32'd50, 32'd5);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_result", result, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Randomized traffic with junk starts and occasional flushes while busy.
      for (int i = 0; i < 150; i++) begin
         issue(rand_ctrl(), rand_operand(), rand_operand());
         for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (!busy) break;
            start = ($urandom_range(0, 7) == 0);
            alu_ctrl = rand_ctrl();
            src_a = $urandom; src_b = $urandom;
            flush = ($urandom_range(0, 63) == 0);
         end
         start = 1'b0; flush = 1'b0;
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
